pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard/sequencing controller for the 5-stage pipeline.
- Generates enable/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC enable.
- Drives stalls for load-use hazards and cache misses, wrong-path flushes for jumps and taken branches, and the halt drain sequence.
- Keeps a saturating stall-cycle counter for the CPU tracker.

Parameters:
- CNT_W, 16, width of stall_cycles counter (saturates at all-ones).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dREN_EX_MEM  in  1  load in MEM stage
- dWEN_EX_MEM  in  1  store in MEM stage
- dREN_ID_EX  in  1  load in EX stage
- Rt_ID_EX  in  5  destination reg of EX-stage load
- rs_IF_ID  in  5  source reg rs of ID-stage instruction
- rt_IF_ID  in  5  source reg rt of ID-stage instruction
- jump_ID  in  1  j/jal/jr decoded in ID (target ready)
- branch_taken_EX_MEM  in  1  branch resolved taken in MEM stage
- halt_ID_EX  in  1  halt in EX stage
- halt_MEM_WB  in  1  halt reached WB
- pc_en  out  1  PC register load enable
- enable_IF_ID, flush_IF_ID  out  1 each  IF/ID control
- enable_ID_EX, flush_ID_EX  out  1 each  ID/EX control
- enable_EX_MEM, flush_EX_MEM  out  1 each  EX/MEM control
- enable_MEM_WB  out  1  MEM/WB control
- halted  out  1  CPU halted, sticky
- stall_cycles  out  CNT_W  cycles with pc_en=0 while not HALTED

Behaviour:
- Flush dominates enable in every pipeline register: flush=1 loads the bubble value.
- Control outputs are combinational from state and inputs.
- FSM states (enum in package):
  - RUN: normal operation.
  - DRAIN: halt in flight; fetch stopped.
  - HALTED: terminal; exited only by reset.
- Reset (nRST=0, async):
  - state=RUN, stall_cycles=0, halted=0.
  - All enables, flushes and pc_en forced 0 while nRST=0.
- Default in RUN (no condition active): all enables=1, all flushes=0, pc_en=1.
- Priority in RUN and DRAIN (first match wins):
  1. Mem freeze: (dREN_EX_MEM|dWEN_EX_MEM) & !dhit → all enables=0, flushes=0, pc_en=0. The dcache has priority, so ihit is ignored.
  2. Branch: branch_taken_EX_MEM → flush_IF_ID=flush_ID_EX=flush_EX_MEM=1, enable_MEM_WB=1, pc_en=1. In DRAIN, next state=RUN (the halt was wrong-path).
  3. Load-use: dREN_ID_EX & Rt_ID_EX!=0 & (Rt_ID_EX==rs_IF_ID | Rt_ID_EX==rt_IF_ID) → pc_en=0, enable_IF_ID=0, flush_ID_EX=1, EX_MEM/MEM_WB enabled.
  4. Jump: jump_ID → flush_IF_ID=1, pc_en=1, others default.
  5. Fetch miss: !ihit → pc_en=0, flush_IF_ID=1, downstream enabled.
- DRAIN:
  - Rules 1-3 apply.
  - Otherwise pc_en=0, flush_IF_ID=1, downstream enabled.
- Transitions:
  - RUN→DRAIN when halt_ID_EX & not rule 1 & not rule 2.
  - RUN or DRAIN→HALTED when halt_MEM_WB & not rule 1. halt_MEM_WB takes precedence over halt_ID_EX.
- HALTED: all enables=0, flushes=0, pc_en=0, halted=1 (registered; asserted the cycle after entry).
- stall_cycles:
  - Increments on each clock edge where pc_en=0 and state!=HALTED.
  - Holds at 2^CNT_W-1.
- Load-use with Rt_ID_EX=0 is never a hazard.
- Simultaneous jump_ID and !ihit: the jump wins. The target loads and IF_ID is flushed.

Decomposition:
- Add to data_path_muxs_pkg or a new pipeline_ctrl_pkg:
  - pipe_state_t enum {RUN, DRAIN, HALTED}
  - pipe_ctrl_t struct bundling enable/flush bits
- Sub-module hazard_detect: purely combinational load-use comparator, instantiated once. The FSM, priority mux and counter stay in the top module.

Test Plan:
- Reset mid-DRAIN: assert nRST=0 → state=RUN, stall_cycles=0, all controls 0 during reset, halted=0.
- Load-use: dREN_ID_EX=1, Rt_ID_EX=5, rs_IF_ID=5, ihit=1 → for one cycle pc_en=0, enable_IF_ID=0, flush_ID_EX=1; stall_cycles=1. Repeat with Rt_ID_EX=0 → no stall.
- dcache miss: dREN_EX_MEM=1, dhit=0 for 3 cycles, branch_taken_EX_MEM=1 concurrently → all enables 0 for 3 cycles, flushes 0. Flush fires the cycle dhit=1; stall_cycles=3.
- Jump with ihit=0: jump_ID=1, ihit=0 → pc_en=1, flush_IF_ID=1.
- Halt drain: halt_ID_EX=1 → DRAIN with pc_en=0, flush_IF_ID=1. Two cycles later halt_MEM_WB=1 → HALTED, halted=1 next cycle, all enables 0 forever.
- Wrong-path halt: in DRAIN, branch_taken_EX_MEM=1 → three flushes asserted, pc_en=1, return to RUN, halted stays 0.
- Counter saturation: CNT_W=4, hold ihit=0 for 20 cycles → stall_cycles=15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller:
// FSM state encoding and the bundle of pipeline-register controls.
package pipeline_ctrl_pkg;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   typedef enum logic [1:0] {
      RUN    = ST_RUN,
      DRAIN  = ST_DRAIN,
      HALTED = ST_HALTED
   } pipe_state_t;

   typedef struct packed {
      logic pc_en;
      logic enable_if_id;
      logic flush_if_id;
      logic enable_id_ex;
      logic flush_id_ex;
      logic enable_ex_mem;
      logic flush_ex_mem;
      logic enable_mem_wb;
   } pipe_ctrl_t;

   // Everything advancing, nothing flushed.
   localparam pipe_ctrl_t CTRL_RUN = '{
      pc_en:         1'b1,
      enable_if_id:  1'b1,
      flush_if_id:   1'b0,
      enable_id_ex:  1'b1,
      flush_id_ex:   1'b0,
      enable_ex_mem: 1'b1,
      flush_ex_mem:  1'b0,
      enable_mem_wb: 1'b1
   };

   localparam pipe_ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls between the controller
// (master) and the datapath (slave).
interface pipeline_ctrl_if #(
   parameter int CNT_W = 16
) ();

   logic             ihit;
   logic             dhit;
   logic             dREN_EX_MEM;
   logic             dWEN_EX_MEM;
   logic             dREN_ID_EX;
   logic [4:0]       Rt_ID_EX;
   logic [4:0]       rs_IF_ID;
   logic [4:0]       rt_IF_ID;
   logic             jump_ID;
   logic             branch_taken_EX_MEM;
   logic             halt_ID_EX;
   logic             halt_MEM_WB;

   logic             pc_en;
   logic             enable_IF_ID;
   logic             flush_IF_ID;
   logic             enable_ID_EX;
   logic             flush_ID_EX;
   logic             enable_EX_MEM;
   logic             flush_EX_MEM;
   logic             enable_MEM_WB;
   logic             halted;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, Rt_ID_EX,
             rs_IF_ID, rt_IF_ID, jump_ID, branch_taken_EX_MEM, halt_ID_EX,
             halt_MEM_WB,
      output pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
             enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halted, stall_cycles
   );

   modport slave (
      output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, Rt_ID_EX,
             rs_IF_ID, rt_IF_ID, jump_ID, branch_taken_EX_MEM, halt_ID_EX,
             halt_MEM_WB,
      input  pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
             enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halted, stall_cycles
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source of
// the instruction in ID. Register 0 never creates a dependency.
module hazard_detect (
   input  logic       dren_id_ex,
   input  logic [4:0] rt_id_ex,
   input  logic [4:0] rs_if_id,
   input  logic [4:0] rt_if_id,
   output logic       load_use
);

   assign load_use = dren_id_ex && (rt_id_ex != 5'd0) &&
                     ((rt_id_ex == rs_if_id) || (rt_id_ex == rt_if_id));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall/flush
// priority mux, RUN/DRAIN/HALTED sequencing and a saturating stall counter.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                CLK,
   input  logic                nRST,
   pipeline_ctrl_if.master     bus,
   output pipe_state_t         dbg_state
);

   pipe_state_t      state;
   pipe_state_t      state_next;
   pipe_ctrl_t       ctrl_raw;
   pipe_ctrl_t       ctrl;
   logic [CNT_W-1:0] cnt;
   logic             halted_q;
   logic             load_use;
   logic             mem_freeze;

   hazard_detect u_hazard_detect (
      .dren_id_ex (bus.dREN_ID_EX),
      .rt_id_ex   (bus.Rt_ID_EX),
      .rs_if_id   (bus.rs_IF_ID),
      .rt_if_id   (bus.rt_IF_ID),
      .load_use   (load_use)
   );

   assign mem_freeze = (bus.dREN_EX_MEM || bus.dWEN_EX_MEM) && !bus.dhit;

   always_comb begin
      ctrl_raw   = CTRL_RUN;
      state_next = state;
      case (state)
         RUN, DRAIN: begin
            if (mem_freeze) begin
               ctrl_raw = CTRL_FREEZE;
            end else if (bus.branch_taken_EX_MEM) begin
               ctrl_raw.flush_if_id  = 1'b1;
               ctrl_raw.flush_id_ex  = 1'b1;
               ctrl_raw.flush_ex_mem = 1'b1;
               // A halt seen while draining was on the wrong path.
               if (state == DRAIN) state_next = RUN;
            end else if (load_use) begin
               ctrl_raw.pc_en        = 1'b0;
               ctrl_raw.enable_if_id = 1'b0;
               ctrl_raw.flush_id_ex  = 1'b1;
            end else if (state == RUN && bus.jump_ID) begin
               ctrl_raw.flush_if_id = 1'b1;
            end else if (state == DRAIN || !bus.ihit) begin
               ctrl_raw.pc_en       = 1'b0;
               ctrl_raw.flush_if_id = 1'b1;
            end

            if (!mem_freeze) begin
               if (bus.halt_MEM_WB)
                  state_next = HALTED;
               else if (state == RUN && bus.halt_ID_EX && !bus.branch_taken_EX_MEM)
                  state_next = DRAIN;
            end
         end
         default: ctrl_raw = CTRL_FREEZE;
      endcase
   end

   assign ctrl = nRST ? ctrl_raw : CTRL_FREEZE;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= RUN;
         halted_q <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_next;
         halted_q <= (state_next == HALTED);
         if (!ctrl.pc_en && state != HALTED && cnt != '1)
            cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.pc_en         = ctrl.pc_en;
   assign bus.enable_IF_ID  = ctrl.enable_if_id;
   assign bus.flush_IF_ID   = ctrl.flush_if_id;
   assign bus.enable_ID_EX  = ctrl.enable_id_ex;
   assign bus.flush_ID_EX   = ctrl.flush_id_ex;
   assign bus.enable_EX_MEM = ctrl.enable_ex_mem;
   assign bus.flush_EX_MEM  = ctrl.flush_ex_mem;
   assign bus.enable_MEM_WB = ctrl.enable_mem_wb;
   assign bus.halted        = halted_q;
   assign bus.stall_cycles  = cnt;
   assign dbg_state         = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl plus hand-written multi-cycle
// sequences (drain, wrong-path halt, dcache miss, reset, saturation).
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   // ctrl bit order: pc_en, en_if_id, fl_if_id, en_id_ex, fl_id_ex,
   //                 en_ex_mem, fl_ex_mem, en_mem_wb
   localparam logic [7:0] C_DEF    = 8'b1101_0101;
   localparam logic [7:0] C_FREEZE = 8'b0000_0000;
   localparam logic [7:0] C_BRANCH = 8'b1111_1111;
   localparam logic [7:0] C_LDUSE  = 8'b0001_1101;
   localparam logic [7:0] C_JUMP   = 8'b1111_0101;
   localparam logic [7:0] C_MISS   = 8'b0111_0101;

   logic        clk;
   logic        n_rst;
   pipe_state_t dbg_state;
   int          checks;
   int          failures;

   pipeline_ctrl_if #(.CNT_W(4)) bus ();

   pipeline_ctrl #(.CNT_W(4)) dut (
      .CLK       (clk),
      .nRST      (n_rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ihit, dhit, dren_mem, dwen_mem, dren_ex;
      logic [4:0]  rt_ex, rs, rt;
      logic        jump, br, halt_ex, halt_wb;
      logic [7:0]  exp_ctrl;
      pipe_state_t exp_state;
      logic [3:0]  exp_stall;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(
      input logic ihit, dhit, dren_mem, dwen_mem, dren_ex,
      input logic [4:0] rt_ex, rs, rt,
      input logic jump, br, halt_ex, halt_wb,
      input logic [7:0] exp_ctrl, input pipe_state_t exp_state,
      input logic [3:0] exp_stall);
      vec_t v;
      v.ihit = ihit; v.dhit = dhit; v.dren_mem = dren_mem; v.dwen_mem = dwen_mem;
      v.dren_ex = dren_ex; v.rt_ex = rt_ex; v.rs = rs; v.rt = rt;
      v.jump = jump; v.br = br; v.halt_ex = halt_ex; v.halt_wb = halt_wb;
      v.exp_ctrl = exp_ctrl; v.exp_state = exp_state; v.exp_stall = exp_stall;
      return v;
   endfunction

   function automatic logic [7:0] act_ctrl();
      return {bus.pc_en, bus.enable_IF_ID, bus.flush_IF_ID, bus.enable_ID_EX,
              bus.flush_ID_EX, bus.enable_EX_MEM, bus.flush_EX_MEM, bus.enable_MEM_WB};
   endfunction

   // scoreboard
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic clear_inputs();
      bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dREN_EX_MEM = 1'b0; bus.dWEN_EX_MEM = 1'b0;
      bus.dREN_ID_EX = 1'b0; bus.Rt_ID_EX = 5'd0; bus.rs_IF_ID = 5'd0; bus.rt_IF_ID = 5'd0;
      bus.jump_ID = 1'b0; bus.branch_taken_EX_MEM = 1'b0;
      bus.halt_ID_EX = 1'b0; bus.halt_MEM_WB = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      bus.ihit = v.ihit; bus.dhit = v.dhit; bus.dREN_EX_MEM = v.dren_mem;
      bus.dWEN_EX_MEM = v.dwen_mem; bus.dREN_ID_EX = v.dren_ex; bus.Rt_ID_EX = v.rt_ex;
      bus.rs_IF_ID = v.rs; bus.rt_IF_ID = v.rt; bus.jump_ID = v.jump;
      bus.branch_taken_EX_MEM = v.br; bus.halt_ID_EX = v.halt_ex; bus.halt_MEM_WB = v.halt_wb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      clear_inputs();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      n_rst    = 1'b0;
      clear_inputs();

      //          ih dh drm dwm dre rt_ex rs     rt     jmp br hx hw  ctrl      state   stall
      vecs[0]  = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_DEF,    RUN,    4'd0);
      vecs[1]  = mk(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, C_LDUSE,  RUN,    4'd1);
      vecs[2]  = mk(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, C_LDUSE,  RUN,    4'd1);
      vecs[3]  = mk(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_DEF,    RUN,    4'd0);
      vecs[4]  = mk(1, 0, 0, 0, 1, 5'd5, 5'd4, 5'd6, 0, 0, 0, 0, C_DEF,    RUN,    4'd0);
      vecs[5]  = mk(1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, C_DEF,    RUN,    4'd0);
      vecs[6]  = mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_FREEZE, RUN,    4'd1);
      vecs[7]  = mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, C_FREEZE, RUN,    4'd1);
      vecs[8]  = mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_DEF,    RUN,    4'd0);
      vecs[9]  = mk(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, C_BRANCH, RUN,    4'd0);
      vecs[10] = mk(1, 0, 0, 0, 1, 5'd9, 5'd0, 5'd9, 1, 0, 0, 0, C_LDUSE,  RUN,    4'd1);
      vecs[11] = mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, C_JUMP,   RUN,    4'd0);
      vecs[12] = mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_MISS,   RUN,    4'd1);
      vecs[13] = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_DEF,    DRAIN,  4'd0);
      vecs[14] = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, C_BRANCH, RUN,    4'd0);
      vecs[15] = mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_FREEZE, RUN,    4'd1);
      vecs[16] = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DEF,    HALTED, 4'd0);
      vecs[17] = mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_FREEZE, RUN,    4'd1);
      vecs[18] = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, C_DEF,    HALTED, 4'd0);

      reset_dut();
      chk("reset state", 32'(dbg_state), 32'(RUN));
      chk("reset stall", 32'(bus.stall_cycles), 32'd0);
      chk("reset halted", 32'(bus.halted), 32'd0);

      for (int i = 0; i < 19; i++) begin
         reset_dut();
         apply(vecs[i]);
         #1;
         chk($sformatf("vec%0d ctrl", i), 32'(act_ctrl()), 32'(vecs[i].exp_ctrl));
         tick();
         chk($sformatf("vec%0d state", i), 32'(dbg_state), 32'(vecs[i].exp_state));
         chk($sformatf("vec%0d stall", i), 32'(bus.stall_cycles), 32'(vecs[i].exp_stall));
         chk($sformatf("vec%0d halted", i), 32'(bus.halted),
             (vecs[i].exp_state == HALTED) ? 32'd1 : 32'd0);
      end

      // Halt drain into HALTED, then HALTED is sticky and frozen.
      reset_dut();
      bus.halt_ID_EX = 1'b1;
      tick();
      bus.halt_ID_EX = 1'b0;
      chk("drain enter", 32'(dbg_state), 32'(DRAIN));
      #1;
      chk("drain ctrl", 32'(act_ctrl()), 32'(C_MISS));
      tick();
      chk("drain stall1", 32'(bus.stall_cycles), 32'd1);
      bus.halt_MEM_WB = 1'b1;
      #1;
      chk("drain ctrl2", 32'(act_ctrl()), 32'(C_MISS));
      tick();
      chk("halt state", 32'(dbg_state), 32'(HALTED));
      chk("halt flag", 32'(bus.halted), 32'd1);
      chk("halt stall", 32'(bus.stall_cycles), 32'd2);
      bus.halt_MEM_WB = 1'b0;
      bus.branch_taken_EX_MEM = 1'b1;
      bus.ihit = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      chk("halted ctrl", 32'(act_ctrl()), 32'(C_FREEZE));
      chk("halted sticky", 32'(dbg_state), 32'(HALTED));
      chk("halted flag2", 32'(bus.halted), 32'd1);
      chk("halted stall hold", 32'(bus.stall_cycles), 32'd2);

      // Reset asserted mid-DRAIN.
      reset_dut();
      bus.halt_ID_EX = 1'b1;
      tick();
      bus.halt_ID_EX = 1'b0;
      tick();
      chk("mid drain stall", 32'(bus.stall_cycles), 32'd1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("rst ctrl", 32'(act_ctrl()), 32'(C_FREEZE));
      chk("rst state", 32'(dbg_state), 32'(RUN));
      chk("rst stall", 32'(bus.stall_cycles), 32'd0);
      chk("rst halted", 32'(bus.halted), 32'd0);
      tick();
      chk("rst ctrl held", 32'(act_ctrl()), 32'(C_FREEZE));
      n_rst = 1'b1;

      // Wrong-path halt: branch while draining returns to RUN.
      reset_dut();
      bus.halt_ID_EX = 1'b1;
      tick();
      bus.halt_ID_EX = 1'b0;
      bus.branch_taken_EX_MEM = 1'b1;
      #1;
      chk("wp ctrl", 32'(act_ctrl()), 32'(C_BRANCH));
      tick();
      chk("wp state", 32'(dbg_state), 32'(RUN));
      chk("wp halted", 32'(bus.halted), 32'd0);
      bus.branch_taken_EX_MEM = 1'b0;
      #1;
      chk("wp ctrl after", 32'(act_ctrl()), 32'(C_DEF));

      // dcache miss for 3 cycles with a concurrent taken branch.
      reset_dut();
      bus.dREN_EX_MEM = 1'b1;
      bus.dhit = 1'b0;
      bus.branch_taken_EX_MEM = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("miss ctrl c%0d", k), 32'(act_ctrl()), 32'(C_FREEZE));
         tick();
      end
      bus.dhit = 1'b1;
      #1;
      chk("miss release ctrl", 32'(act_ctrl()), 32'(C_BRANCH));
      chk("miss stall", 32'(bus.stall_cycles), 32'd3);
      tick();
      chk("miss stall after", 32'(bus.stall_cycles), 32'd3);

      // Counter saturation with CNT_W=4.
      reset_dut();
      bus.ihit = 1'b0;
      for (int k = 0; k < 14; k++) tick();
      chk("cnt 14", 32'(bus.stall_cycles), 32'd14);
      for (int k = 0; k < 6; k++) tick();
      chk("cnt sat", 32'(bus.stall_cycles), 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
